// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - baud codes, divisor lookup and FSM state type for uart_bps_gen
package uart_pkg;

   localparam logic [2:0] BAUD_9600   = 3'd0;
   localparam logic [2:0] BAUD_19200  = 3'd1;
   localparam logic [2:0] BAUD_38400  = 3'd2;
   localparam logic [2:0] BAUD_57600  = 3'd3;
   localparam logic [2:0] BAUD_115200 = 3'd4;
   localparam logic [2:0] BAUD_CUSTOM = 3'd7;

   localparam int UART_MAX_PULSES = 12;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } bps_state_e;

   // Bit period in clock cycles, truncated; unknown codes fall back to 9600.
   function automatic logic [15:0] baud_div(input int unsigned clk_freq,
                                            input logic [2:0] code);
      int unsigned baud;
      case (code)
         BAUD_19200:  baud = 19200;
         BAUD_38400:  baud = 38400;
         BAUD_57600:  baud = 57600;
         BAUD_115200: baud = 115200;
         default:     baud = 9600;
      endcase
      return 16'(clk_freq / baud);
   endfunction

endpackage

// File: rtl/uart_bps_gen.sv
// rtl/uart_bps_gen.sv - UART bit-midpoint pulse generator; optional UART_BPS_RUNTIME_DIV_EN adds a runtime divisor
module uart_bps_gen
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 50000000,
   parameter int          MAX_PULSES = UART_MAX_PULSES
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bps_start,
   input  logic [2:0]  baud_sel,
`ifdef UART_BPS_RUNTIME_DIV_EN
   input  logic        div_wr,
   input  logic [15:0] div_data,
`endif
   output logic        clk_bps,
   output logic        bps_busy,
   output logic        frame_err
);

   localparam int          PW      = $clog2(MAX_PULSES + 2);
   localparam logic [15:0] DEF_DIV = baud_div(CLK_FREQ, BAUD_9600);

   bps_state_e    state, state_next;
   logic [15:0]   active_div;
   logic [15:0]   sel_div;
   logic [15:0]   half_m1;
   logic [15:0]   cnt;
   logic [PW-1:0] pulse_cnt;
   logic          running;
   logic          at_mid;

`ifdef UART_BPS_RUNTIME_DIV_EN
   logic [15:0]   custom_div;

   // Custom divisor is writable only between frames; tiny values are clamped so HALF-1 stays valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         custom_div <= DEF_DIV;
      else if (div_wr && state == IDLE)
         custom_div <= (div_data < 16'd4) ? 16'd4 : div_data;
   end
`endif

   // Divisor selected by the current baud code (sampled only at frame start).
   always_comb begin
      sel_div = baud_div(CLK_FREQ, baud_sel);
`ifdef UART_BPS_RUNTIME_DIV_EN
      if (baud_sel == BAUD_CUSTOM)
         sel_div = custom_div;
`endif
   end

   assign running = (state == RUN) && bps_start;
   assign half_m1 = (active_div >> 1) - 16'd1;
   assign at_mid  = running && (cnt == half_m1);

   // Next-state logic: a frame lasts exactly as long as bps_start is held.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bps_start)  state_next = RUN;
         RUN:     if (!bps_start) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register; busy mirrors the state so it is glitch-free for the receiver.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         bps_busy <= 1'b0;
      end else begin
         state    <= state_next;
         bps_busy <= (state_next == RUN);
      end
   end

   // Divisor is frozen at frame start so mid-frame baud_sel changes cannot skew bit timing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         active_div <= DEF_DIV;
      else if (state == IDLE && bps_start)
         active_div <= sel_div;
   end

   // Bit-period counter; held at zero whenever no frame is running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= 16'd0;
      else if (running)
         cnt <= (cnt == active_div - 16'd1) ? 16'd0 : cnt + 16'd1;
      else
         cnt <= 16'd0;
   end

   // Midpoint pulse, pulse budget and overrun flag; a dropped bps_start cancels everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_bps   <= 1'b0;
         frame_err <= 1'b0;
         pulse_cnt <= '0;
      end else if (running) begin
         clk_bps <= at_mid && (pulse_cnt < PW'(MAX_PULSES));
         if (at_mid && pulse_cnt != PW'(MAX_PULSES + 1))
            pulse_cnt <= pulse_cnt + PW'(1);
         if (at_mid && pulse_cnt == PW'(MAX_PULSES))
            frame_err <= 1'b1;
      end else begin
         clk_bps   <= 1'b0;
         frame_err <= 1'b0;
         pulse_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_uart_bps_gen.sv
// tb/tb_uart_bps_gen.sv - directed self-checking bench for uart_bps_gen
module tb_uart_bps_gen;

   logic        clk;
   logic        rst_n;
   logic        bps_start;
   logic [2:0]  baud_sel;
   logic        clk_bps;
   logic        bps_busy;
   logic        frame_err;
`ifdef UART_BPS_RUNTIME_DIV_EN
   logic        div_wr;
   logic [15:0] div_data;
`endif

   int n_vec = 0;
   int n_err = 0;
   int pt[$];
   int ferr_t;
   int got;

   uart_bps_gen #(.CLK_FREQ(50000000), .MAX_PULSES(12)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bps_start (bps_start),
      .baud_sel  (baud_sel),
`ifdef UART_BPS_RUNTIME_DIV_EN
      .div_wr    (div_wr),
      .div_data  (div_data),
`endif
      .clk_bps   (clk_bps),
      .bps_busy  (bps_busy),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // t = number of edges since the edge that sampled bps_start high
   task automatic collect(input int n);
      pt.delete();
      ferr_t = -1;
      for (int t = 0; t < n; t++) begin
         step();
         if (clk_bps === 1'b1) pt.push_back(t);
         if (frame_err === 1'b1 && ferr_t < 0) ferr_t = t;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; bps_start = 1'b0; baud_sel = 3'd0;
`ifdef UART_BPS_RUNTIME_DIV_EN
      div_wr = 1'b0; div_data = 16'd0;
`endif
      #1;
      n_vec++; if (clk_bps !== 1'b0) begin n_err++; $display("FAIL reset_clk_bps got %b want 0", clk_bps); end
      n_vec++; if (bps_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bps_busy); end
      n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
      repeat (3) step();
      rst_n = 1'b1;
      step();
      n_vec++; if (bps_busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %b want 0", bps_busy); end
   endtask

   task automatic test_9600();
      baud_sel = 3'd0; bps_start = 1'b1;
      collect(2604 + 9 * 5208 + 1000);
      n_vec++; if (bps_busy !== 1'b1) begin n_err++; $display("FAIL b9600_busy got %b want 1", bps_busy); end
      n_vec++; if (pt.size() != 10) begin n_err++; $display("FAIL b9600_count got %0d want 10", pt.size()); end
      for (int k = 0; k < 10; k++) begin
         got = (k < pt.size()) ? pt[k] : -1;
         n_vec++; if (got != 2604 + k * 5208) begin n_err++; $display("FAIL b9600_time[%0d] got %0d want %0d", k, got, 2604 + k * 5208); end
      end
      bps_start = 1'b0;
      step();
      n_vec++; if (bps_busy !== 1'b0) begin n_err++; $display("FAIL b9600_drop_busy got %b want 0", bps_busy); end
      step();
   endtask

   task automatic test_overrun();
      baud_sel = 3'd4; bps_start = 1'b1;
      collect(13 * 434 + 217 + 20);
      n_vec++; if (pt.size() != 12) begin n_err++; $display("FAIL ovr_count got %0d want 12", pt.size()); end
      for (int k = 0; k < 12; k++) begin
         got = (k < pt.size()) ? pt[k] : -1;
         n_vec++; if (got != 217 + k * 434) begin n_err++; $display("FAIL ovr_time[%0d] got %0d want %0d", k, got, 217 + k * 434); end
      end
      n_vec++; if (ferr_t != 217 + 12 * 434) begin n_err++; $display("FAIL ovr_err_time got %0d want %0d", ferr_t, 217 + 12 * 434); end
      n_vec++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL ovr_err_held got %b want 1", frame_err); end
      bps_start = 1'b0;
      step();
      n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL ovr_err_clear got %b want 0", frame_err); end
      step();
   endtask

   task automatic test_baud_change();
      baud_sel = 3'd0; bps_start = 1'b1;
      collect(100);
      baud_sel = 3'd4;
      pt.delete();
      for (int t = 100; t < 2604 + 5208 + 10; t++) begin
         step();
         if (clk_bps === 1'b1) pt.push_back(t);
      end
      n_vec++; if (pt.size() != 2) begin n_err++; $display("FAIL chg_count got %0d want 2", pt.size()); end
      got = (pt.size() > 1) ? pt[1] : -1;
      n_vec++; if (got != 7812) begin n_err++; $display("FAIL chg_second got %0d want 7812", got); end
      bps_start = 1'b0;
      step();
      bps_start = 1'b1;
      collect(700);
      n_vec++; if (pt.size() != 2) begin n_err++; $display("FAIL chg_next_count got %0d want 2", pt.size()); end
      got = (pt.size() > 1) ? pt[1] : -1;
      n_vec++; if (got != 651) begin n_err++; $display("FAIL chg_next_second got %0d want 651", got); end
      bps_start = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      baud_sel = 3'd3; bps_start = 1'b1;
      collect(434);
      n_vec++; if (pt.size() != 0) begin n_err++; $display("FAIL b2b_early got %0d want 0", pt.size()); end
      bps_start = 1'b0;
      step();
      n_vec++; if (clk_bps !== 1'b0) begin n_err++; $display("FAIL b2b_cancel got %b want 0", clk_bps); end
      n_vec++; if (bps_busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy got %b want 0", bps_busy); end
      bps_start = 1'b1; baud_sel = 3'd2;
      collect(2000);
      n_vec++; if (pt.size() != 2) begin n_err++; $display("FAIL b2b_count got %0d want 2", pt.size()); end
      got = (pt.size() > 0) ? pt[0] : -1;
      n_vec++; if (got != 651) begin n_err++; $display("FAIL b2b_first got %0d want 651", got); end
      got = (pt.size() > 1) ? pt[1] : -1;
      n_vec++; if (got != 1953) begin n_err++; $display("FAIL b2b_second got %0d want 1953", got); end
      bps_start = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      baud_sel = 3'd0; bps_start = 1'b1;
      collect(1001);
      rst_n = 1'b0;
      #1;
      n_vec++; if (bps_busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", bps_busy); end
      n_vec++; if (clk_bps !== 1'b0) begin n_err++; $display("FAIL rstmid_clk_bps got %b want 0", clk_bps); end
      repeat (3) step();
      rst_n = 1'b1;
      collect(2700);
      n_vec++; if (pt.size() != 1) begin n_err++; $display("FAIL rstmid_count got %0d want 1", pt.size()); end
      got = (pt.size() > 0) ? pt[0] : -1;
      n_vec++; if (got != 2604) begin n_err++; $display("FAIL rstmid_first got %0d want 2604", got); end
      bps_start = 1'b0;
      step();
   endtask

`ifdef UART_BPS_RUNTIME_DIV_EN
   task automatic test_custom();
      div_wr = 1'b1; div_data = 16'd100;
      step();
      div_wr = 1'b0; baud_sel = 3'd7; bps_start = 1'b1;
      collect(260);
      n_vec++; if (pt.size() != 3) begin n_err++; $display("FAIL cus100_count got %0d want 3", pt.size()); end
      for (int k = 0; k < 3; k++) begin
         got = (k < pt.size()) ? pt[k] : -1;
         n_vec++; if (got != 50 + k * 100) begin n_err++; $display("FAIL cus100_time[%0d] got %0d want %0d", k, got, 50 + k * 100); end
      end
      bps_start = 1'b0;
      step();
      div_wr = 1'b1; div_data = 16'd2;
      step();
      div_wr = 1'b0; bps_start = 1'b1;
      pt.delete();
      for (int t = 0; t < 16; t++) begin
         div_wr = (t == 3); div_data = 16'd100;
         step();
         if (clk_bps === 1'b1) pt.push_back(t);
      end
      div_wr = 1'b0;
      n_vec++; if (pt.size() != 4) begin n_err++; $display("FAIL cus4_count got %0d want 4", pt.size()); end
      for (int k = 0; k < 4; k++) begin
         got = (k < pt.size()) ? pt[k] : -1;
         n_vec++; if (got != 2 + k * 4) begin n_err++; $display("FAIL cus4_time[%0d] got %0d want %0d", k, got, 2 + k * 4); end
      end
      bps_start = 1'b0;
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_9600();
      test_overrun();
      test_baud_change();
      test_back_to_back();
      test_reset_mid();
`ifdef UART_BPS_RUNTIME_DIV_EN
      test_custom();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
